pic_priority_resolver_n: RTL and testbench
==========================================

Name: pic_priority_resolver_n

Overview:
- Clocked, parametrised successor to the 8259-style priority resolver.
- Captures NUM_IRQ interrupt requests in edge or level mode and resolves them against the in-service set with fixed or automatic-rotating priority.
- Runs the two-pulse INTA acknowledge sequence and produces the vector byte.
- Handles non-specific, specific and automatic EOI; sits between the IR pins, the control-word registers and the read/write data-bus logic.

Parameters:
- NUM_IRQ, 8, number of request channels; power of two, 2..8.
- IDX_W, $clog2(NUM_IRQ), width of a channel index.
- VEC_W, 8, width of the vector byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- irq_in  in  NUM_IRQ  raw request lines, already synchronised.
- ltim  in  1  1 = level-triggered, 0 = rising-edge-triggered.
- imr  in  NUM_IRQ  mask register; 1 = channel masked.
- rotate_mode  in  1  1 = automatic rotation on EOI.
- aeoi  in  1  1 = automatic EOI at the second INTA.
- vector_base  in  VEC_W-IDX_W  upper vector bits.
- inta_pulse  in  1  one-cycle strobe per INTA falling edge.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  with eoi_valid: 1 = specific EOI, 0 = non-specific.
- eoi_level  in  IDX_W  channel cleared by a specific EOI.
- int_out  out  1  registered interrupt request to the CPU.
- vector_out  out  VEC_W  vector byte, valid with vector_valid.
- vector_valid  out  1  one-cycle strobe on the second INTA.
- spurious  out  1  one-cycle strobe when ACK1 finds no winner.
- irr_out  out  NUM_IRQ  IRR for status reads.
- isr_out  out  NUM_IRQ  ISR for status reads.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - IRR=0, ISR=0, edge history=0, pri_base=0 (IR0 highest), state=IDLE.
  - int_out=0, vector_out=0, vector_valid=0, spurious=0.
  - Reset during WAIT2 abandons the sequence; no vector is produced.
- Request capture, every cycle:
  - Edge mode: IRR[i] sets when irq_in[i] was 0 last cycle and is 1 now.
  - Level mode: IRR[i] follows irq_in[i] each cycle, except that the ACK1 clear wins for that cycle.
  - IRR latches regardless of imr; imr gates resolution only.
- Priority order:
  - Channel pri_base is highest, then pri_base+1, and so on, modulo NUM_IRQ.
  - With rotate_mode=0, pri_base stays fixed at 0.
- Winner: the highest-priority bit of IRR & ~imr whose priority is strictly above every set ISR bit (fully nested).
- int_out: registered; 1 the cycle after a winner exists; drops the cycle after ACK1 consumes it.
- FSM states: IDLE, WAIT2.
  - IDLE + inta_pulse, winner w exists: ISR[w]<=1, IRR[w]<=0, latch ack_idx=w, go to WAIT2.
  - IDLE + inta_pulse, no winner: latch ack_idx=NUM_IRQ-1, spurious=1 for one cycle, ISR unchanged, go to WAIT2.
  - WAIT2 + inta_pulse:
    - vector_out<={vector_base, ack_idx}, vector_valid=1 for one cycle, return to IDLE.
    - If aeoi=1 and the sequence was not spurious: clear ISR[ack_idx]; if rotate_mode=1, pri_base<=ack_idx+1 mod NUM_IRQ.
  - No timeout in WAIT2.
  - vector_out holds its value until the next WAIT2 completion.
- EOI (eoi_valid=1):
  - Non-specific: clear the highest-priority set ISR bit; no effect if ISR=0.
  - Specific: clear ISR[eoi_level].
  - If rotate_mode=1 and a bit c was actually cleared: pri_base<=c+1 mod NUM_IRQ.
- Simultaneous events:
  - EOI and ACK1 in the same cycle: both apply. The winner is computed from pre-EOI state; if both target the same bit, the ACK1 set wins.
  - AEOI rotation and an EOI rotation in the same cycle: the EOI rotation wins.
- Wrap-around: pri_base = NUM_IRQ-1 rotates to 0.
- Latency:
  - irq edge to int_out: 2 cycles (IRR register, then int_out register).
  - Second inta_pulse to vector_valid: 1 cycle.

Test Plan:
- Fixed priority, edge mode, IR3 and IR5 rise in the same cycle -> int_out=1; ACK1 gives ISR=0x08, IRR=0x20; ACK2 with vector_base=5'b01000 gives vector_out=0x43.
- Nesting: ISR=0x08 pending, IR5 requests -> int_out stays 0; IR1 requests -> int_out=1; non-specific EOI clears ISR[1] first, then ISR[3].
- Rotate mode, aeoi=1, IR7 acknowledged -> ISR returns to 0 after ACK2, pri_base=0; IR2 then acknowledged -> pri_base=3, so IR3 now beats IR2.
- Masking: imr=0x04, IR2 pulses -> irr_out=0x04 and int_out=0; clearing imr -> int_out=1 two cycles later.
- Spurious: IR4 level request drops before ACK1 (ltim=1) -> spurious=1; vector low bits=7; ISR stays 0.
- Reset asserted in WAIT2 -> all outputs 0, state IDLE; the next inta_pulse is treated as ACK1.
- NUM_IRQ=4 build: IR3 acknowledged -> vector_out={vector_base[7:2], 2'b11}.

Source files
------------

// File: rtl/pic_priority_resolver_n.sv
// 8259-style priority resolver: request capture, fully nested resolution with
// optional rotation, two-pulse INTA acknowledge and EOI handling.

module pic_irq_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic ltim_i,
  input  logic clr_i,
  output logic irr_o
);
  logic prev_q, irr_q, irr_d;

  // ACK1 clear wins over a same-cycle edge or level
  always_comb begin
    irr_d = ltim_i ? irq_i : (irr_q | (irq_i & ~prev_q));
    if (clr_i) irr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      irr_q  <= 1'b0;
    end else begin
      prev_q <= irq_i;
      irr_q  <= irr_d;
    end
  end

  assign irr_o = irr_q;
endmodule

module pic_priority_resolver_n #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ),
  parameter int VEC_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   ltim,
  input  logic [NUM_IRQ-1:0]     imr,
  input  logic                   rotate_mode,
  input  logic                   aeoi,
  input  logic [VEC_W-IDX_W-1:0] vector_base,
  input  logic                   inta_pulse,
  input  logic                   eoi_valid,
  input  logic                   eoi_specific,
  input  logic [IDX_W-1:0]       eoi_level,
  output logic                   int_out,
  output logic [VEC_W-1:0]       vector_out,
  output logic                   vector_valid,
  output logic                   spurious,
  output logic [NUM_IRQ-1:0]     irr_out,
  output logic [NUM_IRQ-1:0]     isr_out
);
  typedef enum logic {IDLE, WAIT2} state_t;

  state_t             state_q;
  logic [NUM_IRQ-1:0] irr, req, ack_clr, isr_q, isr_d;
  logic [IDX_W-1:0]   pri_base_q, pri_base_d, ack_idx_q;
  logic [IDX_W-1:0]   scan_ch, win_idx, isr_top, eoi_idx;
  logic               win_vld, isr_any, ack1, ack2, eoi_hit, aeoi_hit;
  logic               seq_spur_q, int_q, vec_valid_q, spur_q;
  logic [VEC_W-1:0]   vec_q;

  assign ack1    = (state_q == IDLE)  && inta_pulse;
  assign ack2    = (state_q == WAIT2) && inta_pulse;
  assign req     = irr & ~imr;
  assign ack_clr = (ack1 && win_vld) ? (NUM_IRQ'(1) << win_idx) : '0;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    pic_irq_chan u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .irq_i  (irq_in[g]),
      .ltim_i (ltim),
      .clr_i  (ack_clr[g]),
      .irr_o  (irr[g])
    );
  end

  // Walk channels from highest priority down; the first in-service bit
  // blocks everything at or below it (fully nested mode).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    isr_any = 1'b0;
    isr_top = '0;
    scan_ch = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      scan_ch = pri_base_q + IDX_W'(k);
      if (isr_q[scan_ch] && !isr_any) begin
        isr_any = 1'b1;
        isr_top = scan_ch;
      end
      if (!isr_any && !win_vld && req[scan_ch]) begin
        win_vld = 1'b1;
        win_idx = scan_ch;
      end
    end
  end

  assign eoi_idx  = eoi_specific ? eoi_level : isr_top;
  assign eoi_hit  = eoi_valid && (eoi_specific ? isr_q[eoi_level] : isr_any);
  assign aeoi_hit = ack2 && aeoi && !seq_spur_q;

  // Order matters: EOI rotation overrides AEOI rotation, ACK1 set overrides clears
  always_comb begin
    isr_d      = isr_q;
    pri_base_d = pri_base_q;
    if (aeoi_hit) begin
      isr_d[ack_idx_q] = 1'b0;
      pri_base_d       = ack_idx_q + IDX_W'(1);
    end
    if (eoi_hit) begin
      isr_d[eoi_idx] = 1'b0;
      pri_base_d     = eoi_idx + IDX_W'(1);
    end
    if (ack1 && win_vld) isr_d[win_idx] = 1'b1;
    if (!rotate_mode || !(aeoi_hit || eoi_hit)) pri_base_d = rotate_mode ? pri_base_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_idx_q   <= '0;
      seq_spur_q  <= 1'b0;
      isr_q       <= '0;
      pri_base_q  <= '0;
      int_q       <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      isr_q       <= isr_d;
      pri_base_q  <= pri_base_d;
      int_q       <= win_vld && !ack1;
      vec_valid_q <= 1'b0;
      spur_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inta_pulse) begin
            ack_idx_q  <= win_vld ? win_idx : IDX_W'(NUM_IRQ - 1);
            seq_spur_q <= !win_vld;
            spur_q     <= !win_vld;
            state_q    <= WAIT2;
          end
        end
        WAIT2: begin
          if (inta_pulse) begin
            vec_q       <= {vector_base, ack_idx_q};
            vec_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign int_out      = int_q;
  assign vector_out   = vec_q;
  assign vector_valid = vec_valid_q;
  assign spurious     = spur_q;
  assign irr_out      = irr;
  assign isr_out      = isr_q;
endmodule

// File: tb/tb_pic_priority_resolver_n.sv
// Scoreboarded bench for pic_priority_resolver_n (8-channel and 4-channel builds).

module tb_pic_priority_resolver_n;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] irq_in = '0, imr = '0, vector_out, irr_out, isr_out;
  logic       ltim = 0, rotate_mode = 0, aeoi = 0, inta_pulse = 0;
  logic       eoi_valid = 0, eoi_specific = 0;
  logic [2:0] eoi_level = '0;
  logic [4:0] vector_base = 5'b01000;
  logic       int_out, vector_valid, spurious;

  logic [3:0] irq4 = '0, irr4, isr4;
  logic [5:0] vb4 = 6'b101010;
  logic [7:0] vec4;
  logic       inta4 = 0, int4, vv4, spur4;

  int         n_tests = 0, n_fail = 0;
  logic [7:0] sb_q[$], sb4_q[$];
  logic [7:0] exp_v, exp_v4;

  always #5 clk = ~clk;

  pic_priority_resolver_n u_dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .ltim(ltim), .imr(imr),
    .rotate_mode(rotate_mode), .aeoi(aeoi), .vector_base(vector_base),
    .inta_pulse(inta_pulse), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .int_out(int_out), .vector_out(vector_out),
    .vector_valid(vector_valid), .spurious(spurious), .irr_out(irr_out), .isr_out(isr_out)
  );

  pic_priority_resolver_n #(.NUM_IRQ(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq4), .ltim(1'b0), .imr(4'h0),
    .rotate_mode(1'b0), .aeoi(1'b0), .vector_base(vb4),
    .inta_pulse(inta4), .eoi_valid(1'b0), .eoi_specific(1'b0),
    .eoi_level(2'd0), .int_out(int4), .vector_out(vec4),
    .vector_valid(vv4), .spurious(spur4), .irr_out(irr4), .isr_out(isr4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inta();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
    tick();
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl;
    tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0;
  endtask

  // Vector scoreboard: expectations pushed before ACK2, popped on vector_valid
  always @(negedge clk) begin
    if (vector_valid) begin
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : ~vector_out;
      chk("vector", 32'(vector_out), 32'(exp_v));
    end
    if (vv4) begin
      exp_v4 = (sb4_q.size() > 0) ? sb4_q.pop_front() : ~vec4;
      chk("vector4", 32'(vec4), 32'(exp_v4));
    end
  end

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_int", 32'(int_out), 0);
    chk("rst_irr", 32'(irr_out), 0);
    chk("rst_isr", 32'(isr_out), 0);
    chk("rst_vec", 32'(vector_out), 0);
    chk("rst_vv", 32'(vector_valid), 0);
    chk("rst_spur", 32'(spurious), 0);
    rst_n = 1'b1;
    tick();

    // fixed priority, IR3 and IR5 together
    irq_in = 8'h28;
    tick();
    chk("t1_irr", 32'(irr_out), 32'h28);
    chk("t1_int_lat", 32'(int_out), 0);
    irq_in = '0;
    tick();
    chk("t1_int", 32'(int_out), 1);
    inta();
    chk("t1_isr", 32'(isr_out), 32'h08);
    chk("t1_irr_ack", 32'(irr_out), 32'h20);
    chk("t1_int_drop", 32'(int_out), 0);
    sb_q.push_back(8'h43);
    inta();

    // nesting
    tick();
    chk("t2_ir5_blocked", 32'(int_out), 0);
    pulse_irq(8'h02);
    chk("t2_ir1_int", 32'(int_out), 1);
    inta();
    chk("t2_isr_nest", 32'(isr_out), 32'h0A);
    sb_q.push_back(8'h41);
    inta();
    eoi(1'b0, 3'd0);
    chk("t2_eoi1", 32'(isr_out), 32'h08);
    eoi(1'b0, 3'd0);
    chk("t2_eoi2", 32'(isr_out), 32'h00);
    tick();
    chk("t2_ir5_int", 32'(int_out), 1);
    inta();
    chk("t2_isr5", 32'(isr_out), 32'h20);
    sb_q.push_back(8'h45);
    inta();
    eoi(1'b1, 3'd5);
    chk("t2_spec_eoi", 32'(isr_out), 32'h00);

    // rotation with AEOI
    rotate_mode = 1'b1; aeoi = 1'b1;
    pulse_irq(8'h80);
    chk("t3_int7", 32'(int_out), 1);
    inta();
    chk("t3_isr7", 32'(isr_out), 32'h80);
    sb_q.push_back(8'h47);
    inta();
    chk("t3_aeoi7", 32'(isr_out), 32'h00);
    pulse_irq(8'h04);
    inta();
    sb_q.push_back(8'h42);
    inta();
    chk("t3_aeoi2", 32'(isr_out), 32'h00);
    pulse_irq(8'h0C);
    inta();
    chk("t3_rot_win", 32'(isr_out), 32'h08);
    chk("t3_rot_irr", 32'(irr_out), 32'h04);
    sb_q.push_back(8'h43);
    inta();
    tick();
    chk("t3_ir2_int", 32'(int_out), 1);
    inta();
    chk("t3_isr2", 32'(isr_out), 32'h04);
    sb_q.push_back(8'h42);
    inta();
    chk("t3_aeoi_end", 32'(isr_out), 32'h00);
    rotate_mode = 1'b0; aeoi = 1'b0;
    tick();

    // masking
    imr = 8'h04;
    pulse_irq(8'h04);
    chk("t4_irr_masked", 32'(irr_out), 32'h04);
    chk("t4_int_masked", 32'(int_out), 0);
    imr = 8'h00;
    tick(); tick();
    chk("t4_int_unmask", 32'(int_out), 1);
    inta();
    sb_q.push_back(8'h42);
    inta();
    eoi(1'b1, 3'd2);

    // spurious: level request withdrawn before ACK1
    ltim = 1'b1;
    irq_in = 8'h10;
    tick(); tick();
    chk("t5_int_lvl", 32'(int_out), 1);
    irq_in = '0;
    tick();
    chk("t5_irr_drop", 32'(irr_out), 0);
    inta();
    chk("t5_spur", 32'(spurious), 1);
    chk("t5_isr", 32'(isr_out), 0);
    sb_q.push_back(8'h47);
    inta();
    ltim = 1'b0;
    tick();

    // reset inside WAIT2
    pulse_irq(8'h40);
    inta();
    chk("t6_isr6", 32'(isr_out), 32'h40);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_isr", 32'(isr_out), 0);
    chk("t6_rst_irr", 32'(irr_out), 0);
    chk("t6_rst_int", 32'(int_out), 0);
    chk("t6_rst_vec", 32'(vector_out), 0);
    chk("t6_rst_vv", 32'(vector_valid), 0);
    rst_n = 1'b1;
    tick();
    inta();
    chk("t6_ack1_after_rst", 32'(spurious), 1);
    sb_q.push_back(8'h47);
    inta();
    tick();

    // NUM_IRQ=4 build
    irq4 = 4'h8;
    tick();
    irq4 = '0;
    tick();
    chk("t7_int4", 32'(int4), 1);
    inta4 = 1'b1; tick(); inta4 = 1'b0;
    chk("t7_isr4", 32'(isr4), 32'h8);
    sb4_q.push_back(8'hAB);
    inta4 = 1'b1; tick(); inta4 = 1'b0;
    tick(); tick();

    chk("sb_drain", 32'(sb_q.size()), 0);
    chk("sb4_drain", 32'(sb4_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
